input_fifo_arbiter: RTL and testbench

//  Shares the 32-bit write port of the compressor input FIFO between NUM_REQ block sources.
//  A grant is held for a whole block, from the first word up to the word flagged Last, so

---
 rtl/lzrw1_pkg.sv | 5 +
 rtl/input_fifo_arbiter_if.sv | 30 +++
 rtl/input_fifo_arbiter_rr_pick.sv | 28 ++
 rtl/input_fifo_arbiter.sv | 102 ++++++++++
 tb/tb_input_fifo_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lzrw1_pkg.sv
// rtl/lzrw1_pkg.sv - shared types and constants for the compressor input arbiter
package lzrw1_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_OWN, ARB_GAP} arb_state_t;
    localparam int FIFO_WORD_W = 32;
endpackage

// File: rtl/input_fifo_arbiter_if.sv
// rtl/input_fifo_arbiter_if.sv - source-side handshake and FIFO write port bundle
interface input_fifo_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int CNT_W   = 16
);
    import lzrw1_pkg::*;
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]             ReqxSI;
    logic [NUM_REQ*FIFO_WORD_W-1:0] DInxDI;
    logic [NUM_REQ-1:0]             LastxSI;
    logic [NUM_REQ-1:0]             AckxSO;
    logic                           FifoBusyxSI;
    logic [FIFO_WORD_W-1:0]         FifoDInxDO;
    logic                           FifoWexSO;
    logic [IDX_W-1:0]               GrantxDO;
    logic                           ActivexSO;
    logic                           BlockDonexSO;
    logic [CNT_W-1:0]               WordCntxDO;

    modport master (
        output ReqxSI, DInxDI, LastxSI, FifoBusyxSI,
        input  AckxSO, FifoDInxDO, FifoWexSO, GrantxDO, ActivexSO, BlockDonexSO, WordCntxDO
    );

    modport slave (
        input  ReqxSI, DInxDI, LastxSI, FifoBusyxSI,
        output AckxSO, FifoDInxDO, FifoWexSO, GrantxDO, ActivexSO, BlockDonexSO, WordCntxDO
    );
endinterface

// File: rtl/input_fifo_arbiter_rr_pick.sv
// rtl/input_fifo_arbiter_rr_pick.sv - cyclic first-set-bit search from a start index
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_start,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_found
);
    int w_cand;

    // Walk offsets from far to near so the closest set bit to i_start wins.
    always_comb begin
        o_idx   = i_start;
        o_found = |i_req;
        w_cand  = 0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            w_cand = int'(i_start) + off;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            if (i_req[w_cand]) begin
                o_idx = IDX_W'(w_cand);
            end
        end
    end
endmodule

// File: rtl/input_fifo_arbiter.sv
// rtl/input_fifo_arbiter.sv - block-granular round-robin arbiter onto the input FIFO write port
module input_fifo_arbiter
    import lzrw1_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int CNT_W   = 16
) (
    input logic                  ClkxCI,
    input logic                  RstxRI,
    input_fifo_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [1:0] S_IDLE = ARB_IDLE;
    localparam logic [1:0] S_OWN  = ARB_OWN;
    localparam logic [1:0] S_GAP  = ARB_GAP;

    logic [1:0]             r_state;
    logic [IDX_W-1:0]       r_ptr;
    logic [IDX_W-1:0]       r_grant;
    logic                   r_we;
    logic [FIFO_WORD_W-1:0] r_dout;
    logic [CNT_W-1:0]       r_cnt;

    logic [IDX_W-1:0]       w_pick;
    logic                   w_found;
    logic [FIFO_WORD_W-1:0] w_din;
    logic                   w_last;
    logic                   w_req_g;
    logic                   w_ack;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req   (bus.ReqxSI),
        .i_start (r_ptr),
        .o_idx   (w_pick),
        .o_found (w_found)
    );

    always_comb begin
        w_din   = '0;
        w_last  = 1'b0;
        w_req_g = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant == IDX_W'(i)) begin
                w_din   = bus.DInxDI[i*FIFO_WORD_W +: FIFO_WORD_W];
                w_last  = bus.LastxSI[i];
                w_req_g = bus.ReqxSI[i];
            end
        end
    end

    // Ack is masked during reset so a source never sees a transfer the FIFO drops.
    assign w_ack = (r_state == S_OWN) && w_req_g && !bus.FifoBusyxSI && !RstxRI;

    assign bus.AckxSO       = w_ack ? (NUM_REQ'(1) << r_grant) : '0;
    assign bus.FifoDInxDO   = r_dout;
    assign bus.FifoWexSO    = r_we;
    assign bus.GrantxDO     = r_grant;
    assign bus.ActivexSO    = (r_state == S_OWN);
    assign bus.BlockDonexSO = (r_state == S_GAP);
    assign bus.WordCntxDO   = r_cnt;

    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
            r_we    <= 1'b0;
            r_dout  <= '0;
            r_cnt   <= '0;
        end else begin
            r_we <= w_ack;
            if (w_ack) begin
                r_dout <= w_din;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_cnt   <= '0;
                        r_state <= S_OWN;
                    end
                end
                S_OWN: begin
                    if (w_ack) begin
                        if (r_cnt != '1) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                        if (w_last) begin
                            r_ptr   <= (r_grant == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + IDX_W'(1);
                            r_state <= S_GAP;
                        end
                    end
                end
                S_GAP:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_input_fifo_arbiter.sv
// tb/tb_input_fifo_arbiter.sv - directed self-checking bench for input_fifo_arbiter
module tb_input_fifo_arbiter;
    logic clk;
    logic rst;
    int   vectors;
    int   errors;

    input_fifo_arbiter_if #(.NUM_REQ(2), .CNT_W(16)) if0 ();
    input_fifo_arbiter_if #(.NUM_REQ(2), .CNT_W(4))  if1 ();

    input_fifo_arbiter #(.NUM_REQ(2), .CNT_W(16)) u_dut (
        .ClkxCI (clk),
        .RstxRI (rst),
        .bus    (if0)
    );

    input_fifo_arbiter #(.NUM_REQ(2), .CNT_W(4)) u_sat (
        .ClkxCI (clk),
        .RstxRI (rst),
        .bus    (if1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ack"},   64'(if0.AckxSO),       64'h0);
        chk({tag, "_we"},    64'(if0.FifoWexSO),    64'h0);
        chk({tag, "_dout"},  64'(if0.FifoDInxDO),   64'h0);
        chk({tag, "_grant"}, 64'(if0.GrantxDO),     64'h0);
        chk({tag, "_act"},   64'(if0.ActivexSO),    64'h0);
        chk({tag, "_done"},  64'(if0.BlockDonexSO), 64'h0);
        chk({tag, "_cnt"},   64'(if0.WordCntxDO),   64'h0);
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst = 1'b1;
        if0.ReqxSI = '0; if0.DInxDI = '0; if0.LastxSI = '0; if0.FifoBusyxSI = 1'b0;
        if1.ReqxSI = '0; if1.DInxDI = '0; if1.LastxSI = '0; if1.FifoBusyxSI = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_reset("rst0");

        // 1: single requester, three-word block
        if0.ReqxSI = 2'b01; if0.DInxDI[31:0] = 32'hA; if0.LastxSI = 2'b00;
        #1; chk("t1_idle_ack", 64'(if0.AckxSO), 64'h0);
        tick(); #1;
        chk("t1_act", 64'(if0.ActivexSO), 64'h1);
        chk("t1_grant", 64'(if0.GrantxDO), 64'h0);
        chk("t1_ackA", 64'(if0.AckxSO), 64'h1);
        chk("t1_we0", 64'(if0.FifoWexSO), 64'h0);
        tick();
        chk("t1_weA", 64'(if0.FifoWexSO), 64'h1);
        chk("t1_dA", 64'(if0.FifoDInxDO), 64'hA);
        chk("t1_cnt1", 64'(if0.WordCntxDO), 64'h1);
        if0.DInxDI[31:0] = 32'hB;
        #1; chk("t1_ackB", 64'(if0.AckxSO), 64'h1);
        tick();
        chk("t1_dB", 64'(if0.FifoDInxDO), 64'hB);
        chk("t1_done0", 64'(if0.BlockDonexSO), 64'h0);
        if0.DInxDI[31:0] = 32'hC; if0.LastxSI = 2'b01;
        #1; chk("t1_ackC", 64'(if0.AckxSO), 64'h1);
        tick();
        chk("t1_dC", 64'(if0.FifoDInxDO), 64'hC);
        chk("t1_weC", 64'(if0.FifoWexSO), 64'h1);
        chk("t1_done", 64'(if0.BlockDonexSO), 64'h1);
        chk("t1_cnt3", 64'(if0.WordCntxDO), 64'h3);
        chk("t1_gap_act", 64'(if0.ActivexSO), 64'h0);
        if0.ReqxSI = 2'b00; if0.LastxSI = 2'b00;
        #1; chk("t1_gap_ack", 64'(if0.AckxSO), 64'h0);
        tick();
        chk("t1_done_end", 64'(if0.BlockDonexSO), 64'h0);
        chk("t1_we_end", 64'(if0.FifoWexSO), 64'h0);
        chk("t1_dhold", 64'(if0.FifoDInxDO), 64'hC);
        chk("t1_cnthold", 64'(if0.WordCntxDO), 64'h3);

        // 2: contention from reset, round-robin between blocks
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if0.ReqxSI = 2'b11; if0.DInxDI = {32'h20, 32'h10};
        #1; chk("t2_idle_ack", 64'(if0.AckxSO), 64'h0);
        tick(); #1;
        chk("t2_g0", 64'(if0.GrantxDO), 64'h0);
        chk("t2_ack0a", 64'(if0.AckxSO), 64'h1);
        tick();
        chk("t2_d10", 64'(if0.FifoDInxDO), 64'h10);
        if0.DInxDI[31:0] = 32'h11; if0.LastxSI = 2'b01;
        #1; chk("t2_ack0b", 64'(if0.AckxSO), 64'h1);
        tick();
        chk("t2_d11", 64'(if0.FifoDInxDO), 64'h11);
        chk("t2_done0", 64'(if0.BlockDonexSO), 64'h1);
        if0.DInxDI[31:0] = 32'h12;
        #1; chk("t2_gap_ack", 64'(if0.AckxSO), 64'h0);
        tick(); #1;
        chk("t2_idle_ack2", 64'(if0.AckxSO), 64'h0);
        chk("t2_idle_we", 64'(if0.FifoWexSO), 64'h0);
        tick(); #1;
        chk("t2_g1", 64'(if0.GrantxDO), 64'h1);
        chk("t2_ack1a", 64'(if0.AckxSO), 64'h2);
        tick();
        chk("t2_d20", 64'(if0.FifoDInxDO), 64'h20);
        if0.DInxDI[63:32] = 32'h21; if0.LastxSI = 2'b11;
        #1; chk("t2_ack1b", 64'(if0.AckxSO), 64'h2);
        tick();
        chk("t2_d21", 64'(if0.FifoDInxDO), 64'h21);
        chk("t2_done1", 64'(if0.BlockDonexSO), 64'h1);
        if0.ReqxSI = 2'b01;
        tick();
        tick(); #1;
        chk("t2_g0b", 64'(if0.GrantxDO), 64'h0);
        chk("t2_ack0c", 64'(if0.AckxSO), 64'h1);
        tick();
        chk("t2_d12", 64'(if0.FifoDInxDO), 64'h12);
        chk("t2_cnt1", 64'(if0.WordCntxDO), 64'h1);
        chk("t2_done0b", 64'(if0.BlockDonexSO), 64'h1);
        if0.ReqxSI = 2'b00; if0.LastxSI = 2'b00;
        tick();

        // 3: backpressure mid-block
        if0.ReqxSI = 2'b01; if0.DInxDI[31:0] = 32'h30;
        tick(); #1;
        chk("t3_ack30", 64'(if0.AckxSO), 64'h1);
        tick();
        chk("t3_d30", 64'(if0.FifoDInxDO), 64'h30);
        if0.DInxDI[31:0] = 32'h31;
        tick();
        chk("t3_d31", 64'(if0.FifoDInxDO), 64'h31);
        chk("t3_we31", 64'(if0.FifoWexSO), 64'h1);
        if0.DInxDI[31:0] = 32'h32; if0.FifoBusyxSI = 1'b1;
        #1; chk("t3_busy_ack0", 64'(if0.AckxSO), 64'h0);
        for (int i = 1; i < 5; i++) begin
            tick(); #1;
            chk($sformatf("t3_busy_ack%0d", i), 64'(if0.AckxSO), 64'h0);
            chk($sformatf("t3_busy_we%0d", i), 64'(if0.FifoWexSO), 64'h0);
        end
        tick();
        chk("t3_busy_we5", 64'(if0.FifoWexSO), 64'h0);
        chk("t3_busy_cnt", 64'(if0.WordCntxDO), 64'h2);
        if0.FifoBusyxSI = 1'b0;
        #1; chk("t3_resume_ack", 64'(if0.AckxSO), 64'h1);
        tick();
        chk("t3_d32", 64'(if0.FifoDInxDO), 64'h32);
        chk("t3_cnt3", 64'(if0.WordCntxDO), 64'h3);
        if0.DInxDI[31:0] = 32'h33; if0.LastxSI = 2'b01;
        tick();
        chk("t3_d33", 64'(if0.FifoDInxDO), 64'h33);
        chk("t3_cnt4", 64'(if0.WordCntxDO), 64'h4);
        if0.ReqxSI = 2'b00; if0.LastxSI = 2'b00;
        tick();

        // 4: owner stalls while the other requester waits
        if0.ReqxSI = 2'b01; if0.DInxDI[31:0] = 32'h40;
        tick(); #1;
        chk("t4_g0", 64'(if0.GrantxDO), 64'h0);
        tick();
        if0.DInxDI[31:0] = 32'h41;
        tick();
        chk("t4_d41", 64'(if0.FifoDInxDO), 64'h41);
        if0.ReqxSI = 2'b10; if0.DInxDI[63:32] = 32'h50;
        #1; chk("t4_stall_ack", 64'(if0.AckxSO), 64'h0);
        for (int i = 0; i < 10; i++) begin
            tick(); #1;
            chk($sformatf("t4_stall_grant%0d", i), 64'(if0.GrantxDO), 64'h0);
            chk($sformatf("t4_stall_ack%0d", i), 64'(if0.AckxSO), 64'h0);
            chk($sformatf("t4_stall_act%0d", i), 64'(if0.ActivexSO), 64'h1);
        end
        if0.ReqxSI = 2'b11; if0.DInxDI[31:0] = 32'h42; if0.LastxSI = 2'b01;
        #1; chk("t4_resume_ack", 64'(if0.AckxSO), 64'h1);
        tick();
        chk("t4_d42", 64'(if0.FifoDInxDO), 64'h42);
        chk("t4_cnt3", 64'(if0.WordCntxDO), 64'h3);
        if0.ReqxSI = 2'b10; if0.LastxSI = 2'b00;
        tick();
        tick(); #1;
        chk("t4_g1", 64'(if0.GrantxDO), 64'h1);
        chk("t4_ack1", 64'(if0.AckxSO), 64'h2);
        if0.LastxSI = 2'b10;
        tick();
        chk("t4_d50", 64'(if0.FifoDInxDO), 64'h50);
        chk("t4_cnt1", 64'(if0.WordCntxDO), 64'h1);
        if0.ReqxSI = 2'b00; if0.LastxSI = 2'b00;
        tick();

        // 5: reset mid-block restarts arbitration from pointer 0
        if0.ReqxSI = 2'b01; if0.DInxDI[31:0] = 32'h5F; if0.LastxSI = 2'b01;
        tick();
        tick();
        chk("t5_d5f", 64'(if0.FifoDInxDO), 64'h5F);
        if0.DInxDI[31:0] = 32'h60; if0.LastxSI = 2'b00;
        tick();
        tick(); #1;
        chk("t5_g0", 64'(if0.GrantxDO), 64'h0);
        tick();
        chk("t5_d60", 64'(if0.FifoDInxDO), 64'h60);
        if0.DInxDI[31:0] = 32'h61;
        tick();
        chk("t5_d61", 64'(if0.FifoDInxDO), 64'h61);
        if0.DInxDI[31:0] = 32'h62; rst = 1'b1;
        tick();
        rst = 1'b0; if0.ReqxSI = 2'b00;
        #1;
        chk_reset("t5_rst");
        if0.ReqxSI = 2'b11; if0.DInxDI[63:32] = 32'h70;
        tick(); #1;
        chk("t5_ptr0_grant", 64'(if0.GrantxDO), 64'h0);
        chk("t5_ptr0_ack", 64'(if0.AckxSO), 64'h1);
        if0.LastxSI = 2'b01;
        tick();
        chk("t5_d62", 64'(if0.FifoDInxDO), 64'h62);
        if0.ReqxSI = 2'b00; if0.LastxSI = 2'b00;
        tick();

        // 6: 20-word block against a 4-bit counter
        if1.ReqxSI = 2'b01; if1.DInxDI[31:0] = 32'h0;
        tick();
        for (int i = 0; i < 20; i++) begin
            if1.DInxDI[31:0] = 32'(i + 256);
            if1.LastxSI = (i == 19) ? 2'b01 : 2'b00;
            #1; chk($sformatf("t6_ack%0d", i), 64'(if1.AckxSO), 64'h1);
            tick();
            chk($sformatf("t6_we%0d", i), 64'(if1.FifoWexSO), 64'h1);
            chk($sformatf("t6_d%0d", i), 64'(if1.FifoDInxDO), 64'(i + 256));
            chk($sformatf("t6_cnt%0d", i), 64'(if1.WordCntxDO), 64'((i + 1 > 15) ? 15 : i + 1));
        end
        chk("t6_done", 64'(if1.BlockDonexSO), 64'h1);
        if1.ReqxSI = 2'b00; if1.LastxSI = 2'b00;
        tick();
        chk("t6_we_end", 64'(if1.FifoWexSO), 64'h0);
        chk("t6_cnt_end", 64'(if1.WordCntxDO), 64'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
